wb_stage: RTL and testbench

- Write-back stage of the 5-stage RV32I pipeline. Registers the MA-stage result and aligns load data from data memory.
- Drives the register-file write port (rd_adr_wb / wbk_rd_reg_wb / wbk_data_wb), which the decode stage and the forwarding unit consume.
- Honours the pipeline stall and roll-back protocol (stall / stall_1shot / stall_dly / rst_pipe).
- Guarantees exactly one RF write per retired instruction.

---
 rtl/wb_stage_if.sv | 34 +++
 rtl/wb_stage.sv | 113 +++++++++++
 tb/tb_wb_stage.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_stage_if.sv
// Bundle of MA-stage inputs, pipeline control and register-file write port
// for the RV32I write-back stage.
interface wb_stage_if;
  logic        inst_valid_ma;
  logic [4:0]  rd_adr_ma;
  logic        wbk_rd_reg_ma;
  logic [31:0] alu_data_ma;
  logic        cmd_ld_ma;
  logic [2:0]  ld_code_ma;
  logic [1:0]  ld_adr_lsb_ma;
  logic [31:0] dmem_rdata;
  logic        stall;
  logic        stall_1shot;
  logic        stall_dly;
  logic        rst_pipe;
  logic [4:0]  rd_adr_wb;
  logic        wbk_rd_reg_wb;
  logic [31:0] wbk_data_wb;
  logic [63:0] instret_wb;

  modport master (
    output inst_valid_ma, rd_adr_ma, wbk_rd_reg_ma, alu_data_ma, cmd_ld_ma,
           ld_code_ma, ld_adr_lsb_ma, dmem_rdata, stall, stall_1shot,
           stall_dly, rst_pipe,
    input  rd_adr_wb, wbk_rd_reg_wb, wbk_data_wb, instret_wb
  );

  modport slave (
    input  inst_valid_ma, rd_adr_ma, wbk_rd_reg_ma, alu_data_ma, cmd_ld_ma,
           ld_code_ma, ld_adr_lsb_ma, dmem_rdata, stall, stall_1shot,
           stall_dly, rst_pipe,
    output rd_adr_wb, wbk_rd_reg_wb, wbk_data_wb, instret_wb
  );
endinterface

// File: rtl/wb_stage.sv
// RV32I write-back stage: registers the MA result, aligns load data and drives
// the RF write port once per instruction. Define WB_INSTRET_EN for instret_wb.
module wb_stage (
  input  logic      clk,
  input  logic      rst_n,
  wb_stage_if.slave bus
);

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd_adr;
    logic        wbk;
    logic [31:0] alu;
    logic        ld;
    logic [2:0]  ld_code;
    logic [1:0]  lsb;
  } wb_regs_t;

  wb_regs_t    pipe_q, pipe_d;
  logic [31:0] ld_roll_q, ld_roll_d;
  logic        written_q, written_d;
  logic        wr_en;
  logic [31:0] ld_src;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_aligned;

  assign wr_en = pipe_q.valid & pipe_q.wbk & (pipe_q.rd_adr != 5'd0) & ~written_q;

  always_comb begin
    pipe_d    = pipe_q;
    ld_roll_d = ld_roll_q;
    written_d = written_q;
    if (!bus.stall) begin
      pipe_d.valid   = bus.inst_valid_ma;
      pipe_d.rd_adr  = bus.rd_adr_ma;
      pipe_d.wbk     = bus.wbk_rd_reg_ma;
      pipe_d.alu     = bus.alu_data_ma;
      pipe_d.ld      = bus.cmd_ld_ma;
      pipe_d.ld_code = bus.ld_code_ma;
      pipe_d.lsb     = bus.ld_adr_lsb_ma;
      written_d      = 1'b0;
    end else if (wr_en) begin
      written_d = 1'b1;
    end
    // The RAM output is not held, so the word is latched on the first stall cycle.
    if (bus.stall_1shot) begin
      ld_roll_d = bus.dmem_rdata;
    end
    if (bus.rst_pipe) begin
      pipe_d    = '0;
      ld_roll_d = '0;
      written_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; the reset sits inside the clocked block (synchronous).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pipe_q    <= '0;
      ld_roll_q <= '0;
      written_q <= 1'b0;
    end else begin
      pipe_q    <= pipe_d;
      ld_roll_q <= ld_roll_d;
      written_q <= written_d;
    end
  end

  always_comb begin
    ld_src = bus.stall_dly ? ld_roll_q : bus.dmem_rdata;
    unique case (pipe_q.lsb)
      2'd0:    ld_byte = ld_src[7:0];
      2'd1:    ld_byte = ld_src[15:8];
      2'd2:    ld_byte = ld_src[23:16];
      default: ld_byte = ld_src[31:24];
    endcase
    ld_half = pipe_q.lsb[1] ? ld_src[31:16] : ld_src[15:0];
    case (pipe_q.ld_code)
      3'b000:  ld_aligned = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_aligned = {24'd0, ld_byte};
      3'b001:  ld_aligned = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_aligned = {16'd0, ld_half};
      default: ld_aligned = ld_src;
    endcase
  end

  assign bus.rd_adr_wb     = pipe_q.rd_adr;
  assign bus.wbk_rd_reg_wb = wr_en;
  assign bus.wbk_data_wb   = pipe_q.ld ? ld_aligned : pipe_q.alu;

`ifdef WB_INSTRET_EN
  logic [63:0] instret_q, instret_d;

  // Counts every instruction leaving WB; a pipeline flush does not rewind it.
  assign instret_d = (pipe_q.valid && !bus.stall && !bus.rst_pipe) ?
                     instret_q + 64'd1 : instret_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instret_q <= '0;
    end else begin
      instret_q <= instret_d;
    end
  end

  assign bus.instret_wb = instret_q;
`else
  assign bus.instret_wb = 64'd0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: expected RF writes are queued by the
// stimulus and popped by a monitor whenever the stage asserts its write enable.
module tb_wb_stage;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  wb_stage_if bus ();

  wb_stage dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  typedef struct packed {
    logic [2:0]  code;
    logic [1:0]  lsb;
    logic [31:0] exp;
  } ld_vec_t;

  // Load word 0x80FF_7F01: bytes b0=01 b1=7F b2=FF b3=80.
  ld_vec_t ld_tab [12] = '{
    '{3'b000, 2'd2, 32'hFFFF_FFFF},  // LB  byte FF
    '{3'b100, 2'd3, 32'h0000_0080},  // LBU byte 80
    '{3'b001, 2'd2, 32'hFFFF_80FF},  // LH  upper half 80FF
    '{3'b101, 2'd0, 32'h0000_7F01},  // LHU lower half 7F01
    '{3'b010, 2'd0, 32'h80FF_7F01},  // LW
    '{3'b000, 2'd1, 32'h0000_007F},  // LB  positive byte
    '{3'b000, 2'd0, 32'h0000_0001},  // LB  byte 0
    '{3'b100, 2'd2, 32'h0000_00FF},  // LBU byte FF
    '{3'b101, 2'd2, 32'h0000_80FF},  // LHU upper half
    '{3'b001, 2'd1, 32'h0000_7F01},  // LH  lsb[0] ignored
    '{3'b011, 2'd1, 32'h80FF_7F01},  // undefined code -> word
    '{3'b111, 2'd3, 32'h80FF_7F01}   // undefined code -> word
  };

  wr_t exp_q[$];
  int  n_vec  = 0;
  int  n_miss = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    wr_t e;
    if (bus.wbk_rd_reg_wb === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_write: rd=%0d data=0x%08h, no write expected",
                 bus.rd_adr_wb, bus.wbk_data_wb);
      end else begin
        e = exp_q.pop_front();
        check("wr_rd", {59'd0, bus.rd_adr_wb}, {59'd0, e.rd});
        check("wr_data", {32'd0, bus.wbk_data_wb}, {32'd0, e.data});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ma(input logic v, input logic [4:0] rd, input logic w,
                        input logic [31:0] alu, input logic ld,
                        input logic [2:0] code, input logic [1:0] lsb);
    bus.inst_valid_ma = v;
    bus.rd_adr_ma     = rd;
    bus.wbk_rd_reg_ma = w;
    bus.alu_data_ma   = alu;
    bus.cmd_ld_ma     = ld;
    bus.ld_code_ma    = code;
    bus.ld_adr_lsb_ma = lsb;
  endtask

  task automatic bubble();
    set_ma(1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 3'd0, 2'd0);
  endtask

  task automatic expect_wr(input logic [4:0] rd, input logic [31:0] data);
    exp_q.push_back('{rd: rd, data: data});
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_rd"}, {59'd0, bus.rd_adr_wb}, 64'd0);
    check({tag, "_we"}, {63'd0, bus.wbk_rd_reg_wb}, 64'd0);
    check({tag, "_data"}, {32'd0, bus.wbk_data_wb}, 64'd0);
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.dmem_rdata  = 32'd0;
    bus.stall       = 1'b0;
    bus.stall_1shot = 1'b0;
    bus.stall_dly   = 1'b0;
    bus.rst_pipe    = 1'b0;
    set_ma(1'b1, 5'd4, 1'b1, 32'hFFFF_FFFF, 1'b0, 3'd0, 2'd0);
    step();
    step();
    check_idle("reset");
    check("reset_instret", bus.instret_wb, 64'd0);
    rst_n = 1'b1;

    // ALU write
    set_ma(1'b1, 5'd5, 1'b1, 32'h1234_5678, 1'b0, 3'd0, 2'd0);
    expect_wr(5'd5, 32'h1234_5678);
    step();

    // Load alignment, one load per cycle
    bus.dmem_rdata = 32'h80FF_7F01;
    for (int i = 0; i < 12; i++) begin
      set_ma(1'b1, 5'(10 + i), 1'b1, 32'h5555_0000, 1'b1, ld_tab[i].code, ld_tab[i].lsb);
      expect_wr(5'(10 + i), ld_tab[i].exp);
      step();
    end

    // x0 destination, then a bubble carrying a write request
    set_ma(1'b1, 5'd0, 1'b1, 32'h0000_DEAD, 1'b0, 3'd0, 2'd0);
    step();
    check("x0_we", {63'd0, bus.wbk_rd_reg_wb}, 64'd0);
    set_ma(1'b0, 5'd3, 1'b1, 32'h0000_BEEF, 1'b0, 3'd0, 2'd0);
    step();
    check("bubble_we", {63'd0, bus.wbk_rd_reg_wb}, 64'd0);

    // Load held across a 4-cycle stall while the RAM output changes
    bus.dmem_rdata = 32'd0;
    set_ma(1'b1, 5'd7, 1'b1, 32'hFFFF_0000, 1'b1, 3'b010, 2'd0);
    step();
    bus.dmem_rdata  = 32'hCAFE_BABE;
    bus.stall       = 1'b1;
    bus.stall_1shot = 1'b1;
    expect_wr(5'd7, 32'hCAFE_BABE);
    set_ma(1'b1, 5'd8, 1'b1, 32'h0000_0011, 1'b0, 3'd0, 2'd0);
    expect_wr(5'd8, 32'h0000_0011);
    #1;
    check("stall_first_data", {32'd0, bus.wbk_data_wb}, 64'hCAFE_BABE);
    check("stall_first_we", {63'd0, bus.wbk_rd_reg_wb}, 64'd1);
    step();
    bus.stall_1shot = 1'b0;
    bus.stall_dly   = 1'b1;
    bus.dmem_rdata  = 32'd0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_hold_data", {32'd0, bus.wbk_data_wb}, 64'hCAFE_BABE);
      check("stall_hold_we", {63'd0, bus.wbk_rd_reg_wb}, 64'd0);
      step();
    end
    bus.stall = 1'b0;
    #1;
    check("stall_release_data", {32'd0, bus.wbk_data_wb}, 64'hCAFE_BABE);
    check("stall_release_we", {63'd0, bus.wbk_rd_reg_wb}, 64'd0);
    step();
    bus.stall_dly = 1'b0;
    bubble();
    step();

    // rst_pipe while a written instruction sits stalled in WB
    set_ma(1'b1, 5'd9, 1'b1, 32'h0000_0099, 1'b0, 3'd0, 2'd0);
    expect_wr(5'd9, 32'h0000_0099);
    step();
    bus.stall       = 1'b1;
    bus.stall_1shot = 1'b1;
    bubble();
    step();
    bus.stall_1shot = 1'b0;
    bus.stall_dly   = 1'b1;
    bus.rst_pipe    = 1'b1;
    step();
    bus.rst_pipe  = 1'b0;
    bus.stall     = 1'b0;
    bus.stall_dly = 1'b0;
    check_idle("flush");
    step();
    check("flush_after_we", {63'd0, bus.wbk_rd_reg_wb}, 64'd0);

    // rst_n asserted mid-stall
    set_ma(1'b1, 5'd10, 1'b1, 32'h0000_00A5, 1'b0, 3'd0, 2'd0);
    expect_wr(5'd10, 32'h0000_00A5);
    step();
    bus.stall       = 1'b1;
    bus.stall_1shot = 1'b1;
    bubble();
    step();
    bus.stall_1shot = 1'b0;
    bus.stall_dly   = 1'b1;
    rst_n = 1'b0;
    step();
    check_idle("rstn");
    check("rstn_instret", bus.instret_wb, 64'd0);
    rst_n         = 1'b1;
    bus.stall     = 1'b0;
    bus.stall_dly = 1'b0;
    step();

    // 10 retiring instructions (stores and x0 writes), 3 stalls, 2 bubbles
    for (int i = 0; i < 10; i++) begin
      set_ma(1'b1, 5'd0, (i % 2 == 0), 32'h100 + i, 1'b0, 3'd0, 2'd0);
      step();
      if (i == 2 || i == 5 || i == 8) begin
        bus.stall       = 1'b1;
        bus.stall_1shot = 1'b1;
        step();
        bus.stall       = 1'b0;
        bus.stall_1shot = 1'b0;
      end
      if (i == 3 || i == 7) begin
        bubble();
        step();
      end
    end
    bubble();
    step();
    step();
`ifdef WB_INSTRET_EN
    check("instret", bus.instret_wb, 64'd10);
`else
    check("instret", bus.instret_wb, 64'd0);
`endif

    step();
    check("pending_writes", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
